// File: rtl/vga_rx_pkg.sv
// Shared types, nominal 640x480@60 timing and checksum step for the VGA receive monitor.
package vga_rx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MEASURE,
      LOCKED
   } state_e;

   localparam int unsigned NOM_H_ACTIVE = 640;
   localparam int unsigned NOM_H_TOTAL  = 800;
   localparam int unsigned NOM_V_ACTIVE = 480;
   localparam int unsigned NOM_V_TOTAL  = 525;

   // One checksum step over a w-bit accumulator (w <= 64): rotate left by one, then xor in the pixel.
   function automatic logic [63:0] ck_step(input logic [63:0] ck,
                                           input logic [23:0] rgb,
                                           input int unsigned w);
      logic [63:0] mask;
      logic [63:0] rot;
      mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      rot  = ((ck << 1) | (ck >> (w - 1))) & mask;
      return (rot ^ {40'd0, rgb}) & mask;
   endfunction

endpackage

// File: rtl/vga_rx_monitor_if.sv
// VGA pin bundle as produced by procesador; the monitor only ever observes it.
interface vga_rx_monitor_if;
   logic       vgaclk;
   logic       hsync;
   logic       vsync;
   logic       blank_b;
   logic [7:0] r;
   logic [7:0] g;
   logic [7:0] b;

   modport master (output vgaclk, hsync, vsync, blank_b, r, g, b);
   modport slave  (input  vgaclk, hsync, vsync, blank_b, r, g, b);
endinterface

// File: rtl/vga_rx_sampler.sv
// Registers the VGA pins into clk, derives the pixel strobe and sync leading edges.
module vga_rx_sampler #(
   parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   vga_rx_monitor_if.slave  vga,
   output logic             px_en,
   output logic             hs_start,
   output logic             vs_start,
   output logic             blank,
   output logic [23:0]      rgb
);

   localparam logic SYNC_ON  = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
   localparam logic SYNC_OFF = ~SYNC_ON;

   logic        vgaclk_s1_q, vgaclk_s1_d;
   logic        vgaclk_s2_q, vgaclk_s2_d;
   logic        hsync_s1_q,  hsync_s1_d;
   logic        vsync_s1_q,  vsync_s1_d;
   logic        blank_s1_q,  blank_s1_d;
   logic [23:0] rgb_s1_q,    rgb_s1_d;
   logic        hs_prev_q,   hs_prev_d;
   logic        vs_prev_q,   vs_prev_d;

   // Strobe, edge detection and next-state of the capture registers.
   always_comb begin
      px_en    = vgaclk_s1_q & ~vgaclk_s2_q;
      hs_start = px_en && (hsync_s1_q == SYNC_ON) && (hs_prev_q != SYNC_ON);
      vs_start = px_en && (vsync_s1_q == SYNC_ON) && (vs_prev_q != SYNC_ON);
      blank    = blank_s1_q;
      rgb      = rgb_s1_q;

      vgaclk_s1_d = vga.vgaclk;
      vgaclk_s2_d = vgaclk_s1_q;
      hsync_s1_d  = vga.hsync;
      vsync_s1_d  = vga.vsync;
      blank_s1_d  = vga.blank_b;
      rgb_s1_d    = {vga.r, vga.g, vga.b};
      // Previous sync levels only advance per pixel so edges are seen in the pixel domain.
      hs_prev_d   = px_en ? hsync_s1_q : hs_prev_q;
      vs_prev_d   = px_en ? vsync_s1_q : vs_prev_q;
   end

   // Capture registers; sync registers idle at the deasserted level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vgaclk_s1_q <= 1'b0;
         vgaclk_s2_q <= 1'b0;
         hsync_s1_q  <= SYNC_OFF;
         vsync_s1_q  <= SYNC_OFF;
         blank_s1_q  <= 1'b0;
         rgb_s1_q    <= '0;
         hs_prev_q   <= SYNC_OFF;
         vs_prev_q   <= SYNC_OFF;
      end else begin
         vgaclk_s1_q <= vgaclk_s1_d;
         vgaclk_s2_q <= vgaclk_s2_d;
         hsync_s1_q  <= hsync_s1_d;
         vsync_s1_q  <= vsync_s1_d;
         blank_s1_q  <= blank_s1_d;
         rgb_s1_q    <= rgb_s1_d;
         hs_prev_q   <= hs_prev_d;
         vs_prev_q   <= vs_prev_d;
      end
   end

endmodule

// File: rtl/vga_rx_monitor.sv
// Measures VGA line/frame timing against the nominal mode, declares lock and checksums each frame.
module vga_rx_monitor
   import vga_rx_pkg::*;
#(
   parameter int unsigned H_ACTIVE        = NOM_H_ACTIVE,
   parameter int unsigned H_TOTAL         = NOM_H_TOTAL,
   parameter int unsigned V_ACTIVE        = NOM_V_ACTIVE,
   parameter int unsigned V_TOTAL         = NOM_V_TOTAL,
   parameter bit          SYNC_ACTIVE_LOW = 1'b1,
   parameter int unsigned CK_W            = 32
) (
   input  logic             clk,
   input  logic             rst,
   vga_rx_monitor_if.slave  vga,
   input  logic             clr_err,
   output logic             locked,
   output logic             frame_done,
   output logic [CK_W-1:0]  frame_cksum,
   output logic [15:0]      frame_count,
   output logic [11:0]      h_meas,
   output logic [10:0]      v_meas,
   output logic             err_h,
   output logic             err_v,
   output logic             err_act
);

   localparam logic [11:0] H_TOTAL_L = 12'(H_TOTAL);
   localparam logic [10:0] V_TOTAL_L = 11'(V_TOTAL);
   localparam logic [19:0] ACTIVE_L  = 20'(H_ACTIVE * V_ACTIVE);

   logic        px_en, hs_start, vs_start, blank;
   logic [23:0] rgb;

   vga_rx_sampler #(
      .SYNC_ACTIVE_LOW (SYNC_ACTIVE_LOW)
   ) u_sampler (
      .clk      (clk),
      .rst      (rst),
      .vga      (vga),
      .px_en    (px_en),
      .hs_start (hs_start),
      .vs_start (vs_start),
      .blank    (blank),
      .rgb      (rgb)
   );

   state_e          state_q, state_d;
   logic [11:0]     h_cnt_q, h_cnt_d;
   logic            hseen_q, hseen_d;
   logic [10:0]     line_q, line_d;
   logic [19:0]     act_q, act_d;
   logic [CK_W-1:0] ck_q, ck_d;
   logic            hmis_q, hmis_d;
   logic            locked_q, locked_d;
   logic            frame_done_q, frame_done_d;
   logic [CK_W-1:0] frame_cksum_q, frame_cksum_d;
   logic [15:0]     frame_count_q, frame_count_d;
   logic [11:0]     h_meas_q, h_meas_d;
   logic [10:0]     v_meas_q, v_meas_d;
   logic            err_h_q, err_h_d;
   logic            err_v_q, err_v_d;
   logic            err_act_q, err_act_d;

   logic            h_bad, v_bad, a_bad, frame_ok;
   logic [CK_W-1:0] ck_next, ck_first;
   logic [10:0]     line_inc;
   logic [19:0]     act_inc;

   // Per-pixel counting, frame close, lock FSM and sticky error flags.
   always_comb begin
      state_d       = state_q;
      h_cnt_d       = h_cnt_q;
      hseen_d       = hseen_q;
      line_d        = line_q;
      act_d         = act_q;
      ck_d          = ck_q;
      hmis_d        = hmis_q;
      locked_d      = locked_q;
      frame_done_d  = 1'b0;
      frame_cksum_d = frame_cksum_q;
      frame_count_d = frame_count_q;
      h_meas_d      = h_meas_q;
      v_meas_d      = v_meas_q;
      h_bad         = 1'b0;
      v_bad         = 1'b0;
      a_bad         = 1'b0;
      frame_ok      = 1'b0;
      ck_next       = CK_W'(ck_step(64'(ck_q), rgb, CK_W));
      ck_first      = CK_W'(ck_step('0, rgb, CK_W));
      line_inc      = (line_q == '1) ? line_q : line_q + 11'd1;
      act_inc       = (act_q == '1) ? act_q : act_q + 20'd1;

      if (px_en) begin
         if (hs_start) begin
            h_meas_d = h_cnt_q;
            h_cnt_d  = 12'd1;
            hseen_d  = 1'b1;
            h_bad    = hseen_q && (h_cnt_q != H_TOTAL_L);
            line_d   = line_inc;
         end else begin
            h_cnt_d  = (h_cnt_q == '1) ? h_cnt_q : h_cnt_q + 12'd1;
         end
         if (h_bad) hmis_d = 1'b1;

         if (blank) begin
            act_d = act_inc;
            ck_d  = ck_next;
         end

         if (vs_start) begin
            // The line closes before the frame: checks use pre-pixel totals, while the
            // coincident line (and this pixel, if active) seeds the new frame.
            if (state_q != IDLE) begin
               v_bad         = (line_q != V_TOTAL_L);
               a_bad         = (act_q != ACTIVE_L);
               frame_ok      = !v_bad && !a_bad && !hmis_q && !h_bad;
               frame_cksum_d = ck_q;
               v_meas_d      = line_q;
               frame_done_d  = 1'b1;
               frame_count_d = frame_count_q + 16'd1;
               locked_d      = frame_ok;
            end
            unique case (state_q)
               IDLE:    state_d = MEASURE;
               MEASURE: state_d = frame_ok ? LOCKED : MEASURE;
               LOCKED:  state_d = frame_ok ? LOCKED : MEASURE;
               default: state_d = IDLE;
            endcase
            line_d = hs_start ? 11'd1 : '0;
            act_d  = blank ? 20'd1 : '0;
            ck_d   = blank ? ck_first : '0;
            hmis_d = 1'b0;
         end
      end

      err_h_d   = (err_h_q   & ~clr_err) | h_bad;
      err_v_d   = (err_v_q   & ~clr_err) | v_bad;
      err_act_d = (err_act_q & ~clr_err) | a_bad;
   end

   // All monitor state, including the lock FSM and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         h_cnt_q       <= '0;
         hseen_q       <= 1'b0;
         line_q        <= '0;
         act_q         <= '0;
         ck_q          <= '0;
         hmis_q        <= 1'b0;
         locked_q      <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_cksum_q <= '0;
         frame_count_q <= '0;
         h_meas_q      <= '0;
         v_meas_q      <= '0;
         err_h_q       <= 1'b0;
         err_v_q       <= 1'b0;
         err_act_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         h_cnt_q       <= h_cnt_d;
         hseen_q       <= hseen_d;
         line_q        <= line_d;
         act_q         <= act_d;
         ck_q          <= ck_d;
         hmis_q        <= hmis_d;
         locked_q      <= locked_d;
         frame_done_q  <= frame_done_d;
         frame_cksum_q <= frame_cksum_d;
         frame_count_q <= frame_count_d;
         h_meas_q      <= h_meas_d;
         v_meas_q      <= v_meas_d;
         err_h_q       <= err_h_d;
         err_v_q       <= err_v_d;
         err_act_q     <= err_act_d;
      end
   end

   assign locked      = locked_q;
   assign frame_done  = frame_done_q;
   assign frame_cksum = frame_cksum_q;
   assign frame_count = frame_count_q;
   assign h_meas      = h_meas_q;
   assign v_meas      = v_meas_q;
   assign err_h       = err_h_q;
   assign err_v       = err_v_q;
   assign err_act     = err_act_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor in a small 4x3 (8x5 total) mode with a frame scoreboard.
module tb_vga_rx_monitor;

   localparam int HA  = 4;
   localparam int HT  = 8;
   localparam int VA  = 3;
   localparam int VT  = 5;
   localparam int CKW = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr_err;
   logic        locked, frame_done;
   logic [31:0] frame_cksum;
   logic [15:0] frame_count;
   logic [11:0] h_meas;
   logic [10:0] v_meas;
   logic        err_h, err_v, err_act;

   vga_rx_monitor_if vif ();

   vga_rx_monitor #(
      .H_ACTIVE        (HA),
      .H_TOTAL         (HT),
      .V_ACTIVE        (VA),
      .V_TOTAL         (VT),
      .SYNC_ACTIVE_LOW (1'b1),
      .CK_W            (CKW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .vga         (vif),
      .clr_err     (clr_err),
      .locked      (locked),
      .frame_done  (frame_done),
      .frame_cksum (frame_cksum),
      .frame_count (frame_count),
      .h_meas      (h_meas),
      .v_meas      (v_meas),
      .err_h       (err_h),
      .err_v       (err_v),
      .err_act     (err_act)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] ck;
      logic [10:0] v;
      logic [11:0] h;
      logic        lk;
      logic [15:0] fc;
      logic        eh;
      logic        ev;
      logic        ea;
   } exp_t;

   exp_t        sbq[$];
   logic        m_eh = 1'b0, m_ev = 1'b0, m_ea = 1'b0;
   logic [15:0] m_fc = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer: each frame_done pops the oldest expected frame.
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst === 1'b0 && frame_done === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("unexpected_frame_done", 32'(frame_count), 32'hFFFF_FFFF);
         end else begin
            e = sbq.pop_front();
            chk("frame_cksum", frame_cksum, e.ck);
            chk("v_meas", 32'(v_meas), 32'(e.v));
            chk("h_meas", 32'(h_meas), 32'(e.h));
            chk("locked", 32'(locked), 32'(e.lk));
            chk("frame_count", 32'(frame_count), 32'(e.fc));
            chk("err_h", 32'(err_h), 32'(e.eh));
            chk("err_v", 32'(err_v), 32'(e.ev));
            chk("err_act", 32'(err_act), 32'(e.ea));
         end
      end
   end

   // One pixel = two clk: vgaclk high then low; clr_err (if requested) lines up with px_en processing.
   task automatic pixel(input logic hs, input logic vs, input logic bl,
                        input logic [23:0] v, input logic pclr);
      @(negedge clk);
      vif.vgaclk  = 1'b1;
      vif.hsync   = hs;
      vif.vsync   = vs;
      vif.blank_b = bl;
      {vif.r, vif.g, vif.b} = v;
      clr_err     = 1'b0;
      @(negedge clk);
      vif.vgaclk  = 1'b0;
      clr_err     = pclr;
   endtask

   task automatic send_line(input int l, input int nl, input int long_l, input int drop_l,
                            input int drop_c, input bit coinc, input bit clrvs);
      int  len;
      bit  vs_on, bl, vs_px;
      len = HT + ((l == long_l) ? 1 : 0);
      for (int c = 0; c < len; c++) begin
         vs_on = coinc ? (l == nl - 1 && c >= 5) : (l == nl - 1);
         vs_px = (l == nl - 1) && (c == (coinc ? 5 : 0));
         bl    = (l < VA) && (c < HA) && !(l == drop_l && c == drop_c);
         pixel((c == 5) ? 1'b0 : 1'b1, !vs_on, bl, 24'(l * 16 + c), clrvs && vs_px);
      end
   endtask

   task automatic send_frame(input int nl, input int long_l, input int drop_l, input int drop_c,
                             input bit coinc, input bit clrvs, input bit prime);
      logic [31:0] ck;
      int          act, hl;
      bit          hm, vm, am;
      exp_t        e;
      if (!prime) begin
         ck  = '0;
         act = 0;
         for (int l = 0; l < VA; l++)
            for (int c = 0; c < HA; c++)
               if (!(l == drop_l && c == drop_c)) begin
                  ck = {ck[30:0], ck[31]} ^ 32'(l * 16 + c);
                  act++;
               end
         hm   = (long_l >= 0);
         vm   = (nl != VT);
         am   = (act != HA * VA);
         hl   = coinc ? nl - 2 : nl - 3;
         m_eh = (clrvs ? 1'b0 : m_eh) | hm;
         m_ev = (clrvs ? 1'b0 : m_ev) | vm;
         m_ea = (clrvs ? 1'b0 : m_ea) | am;
         m_fc = m_fc + 16'd1;
         e.ck = ck;
         e.v  = 11'(nl);
         e.h  = (hl == long_l) ? 12'(HT + 1) : 12'(HT);
         e.lk = !hm && !vm && !am;
         e.fc = m_fc;
         e.eh = m_eh;
         e.ev = m_ev;
         e.ea = m_ea;
         sbq.push_back(e);
      end
      for (int l = 0; l < nl; l++) send_line(l, nl, long_l, drop_l, drop_c, coinc, clrvs);
   endtask

   task automatic do_clr();
      @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      m_eh = 1'b0;
      m_ev = 1'b0;
      m_ea = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_locked"}, 32'(locked), 32'd0);
      chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
      chk({tag, "_frame_cksum"}, frame_cksum, 32'd0);
      chk({tag, "_frame_count"}, 32'(frame_count), 32'd0);
      chk({tag, "_h_meas"}, 32'(h_meas), 32'd0);
      chk({tag, "_v_meas"}, 32'(v_meas), 32'd0);
      chk({tag, "_errs"}, 32'({err_h, err_v, err_act}), 32'd0);
   endtask

   initial begin
      rst         = 1'b1;
      clr_err     = 1'b0;
      vif.vgaclk  = 1'b0;
      vif.hsync   = 1'b1;
      vif.vsync   = 1'b1;
      vif.blank_b = 1'b0;
      vif.r       = '0;
      vif.g       = '0;
      vif.b       = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;

      // Priming frame: first vsync only arms measurement.
      send_frame(VT, -1, -1, -1, 1'b0, 1'b0, 1'b1);
      chk("prime_locked", 32'(locked), 32'd0);
      chk("prime_frame_count", 32'(frame_count), 32'd0);
      // Clean frames.
      repeat (3) send_frame(VT, -1, -1, -1, 1'b0, 1'b0, 1'b0);
      // Line 2 nine pixels long, then a clean recovery frame with err_h still sticky.
      send_frame(VT, 2, -1, -1, 1'b0, 1'b0, 1'b0);
      send_frame(VT, -1, -1, -1, 1'b0, 1'b0, 1'b0);
      do_clr();
      chk("clr_err_h", 32'(err_h), 32'd0);
      // Six lines with clr_err on the closing clk: the new err_v must survive.
      send_frame(VT + 1, -1, -1, -1, 1'b0, 1'b1, 1'b0);
      send_frame(VT, -1, -1, -1, 1'b0, 1'b0, 1'b0);
      do_clr();
      chk("clr_err_v", 32'(err_v), 32'd0);
      // One active pixel blanked.
      send_frame(VT, -1, 1, 2, 1'b0, 1'b0, 1'b0);
      do_clr();
      chk("clr_err_act", 32'(err_act), 32'd0);
      // Coincident hsync/vsync leading edges.
      repeat (3) send_frame(VT, -1, -1, -1, 1'b1, 1'b0, 1'b0);
      send_frame(VT, -1, -1, -1, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of a frame.
      send_line(0, VT, -1, -1, -1, 1'b0, 1'b0);
      send_line(1, VT, -1, -1, -1, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_all_zero("midrst");
      chk("sbq_empty_at_rst", 32'(sbq.size()), 32'd0);
      m_eh = 1'b0;
      m_ev = 1'b0;
      m_ea = 1'b0;
      m_fc = '0;
      @(negedge clk);
      rst = 1'b0;
      send_frame(VT, -1, -1, -1, 1'b0, 1'b0, 1'b1);
      chk("reprime_locked", 32'(locked), 32'd0);
      chk("reprime_frame_count", 32'(frame_count), 32'd0);
      send_frame(VT, -1, -1, -1, 1'b0, 1'b0, 1'b0);

      repeat (20) @(negedge clk);
      chk("sbq_drained", 32'(sbq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vga_rx_monitor.md
Name: vga_rx_monitor

Overview:
- Receive-side counterpart of the `procesador` VGA output. It samples vgaclk/hsync/vsync/blank_b/r/g/b in the system clock domain.
- Measures line and frame timing against the nominal mode and declares lock.
- Produces a per-frame checksum of the active pixels, so the encryption CPU's displayed image can be checked in simulation and on FPGA without a monitor.
- Placed beside `procesador` in the top-level harness; purely observing, never drives the VGA pins.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 800, pixel clocks per line (hsync-assert to hsync-assert)
- V_ACTIVE, 480, active lines per frame
- V_TOTAL, 525, lines per frame (vsync-assert to vsync-assert)
- SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync assert low
- CK_W, 32, checksum width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- vgaclk  in  1  pixel clock from procesador, sampled as data
- hsync  in  1  horizontal sync
- vsync  in  1  vertical sync
- blank_b  in  1  1 = active video
- r, g, b  in  8 each  pixel colour
- clr_err  in  1  clears sticky error flags
- locked  out  1  last complete frame matched all nominal counts
- frame_done  out  1  one-clk pulse when a frame closes
- frame_cksum  out  CK_W  checksum of last closed frame
- frame_count  out  16  closed frames since reset, wraps
- h_meas  out  12  last measured line length
- v_meas  out  11  last measured lines per frame
- err_h, err_v, err_act  out  1 each  sticky mismatch flags

Behaviour:
- Reset values:
  - All outputs 0.
  - Internal counters 0.
  - State IDLE.
  - Input registers 0; sync registers hold the deasserted level.
- Pixel strobe:
  - vgaclk, hsync, vsync, blank_b and rgb are registered once (stage 1). vgaclk is also registered a second time (stage 2).
  - px_en = stage-1 vgaclk high and stage-2 vgaclk low, i.e. a vgaclk rising edge.
  - All sampling and counting happens on px_en only.
  - The stage-1 values of hsync/vsync/blank_b/rgb are the sample used.
- Sync edges (evaluated on px_en):
  - hs_start = hsync transitions into its asserted level (per SYNC_ACTIVE_LOW).
  - vs_start = same rule for vsync.
- h counter:
  - Increments on each px_en and saturates at 4095.
  - On hs_start: h_meas <= count; the counter reloads to 1.
  - err_h is set if count != H_TOTAL, but only once a previous hs_start has been seen since reset. The first partial line is never checked.
- line counter: increments on hs_start and saturates at 2047.
- active counter (20 bit): increments on px_en when blank_b = 1.
- Checksum: on px_en with blank_b = 1, ck <= rotl(ck, 1) XOR zero-extended {r, g, b}.
- Frame close, on vs_start in state MEASURE or LOCKED:
  - frame_cksum <= ck; v_meas <= line counter.
  - frame_done pulses high for 1 clk.
  - frame_count increments.
  - err_v is set if v_meas != V_TOTAL; err_act is set if active != H_ACTIVE*V_ACTIVE.
  - The frame matches only if both of those checks pass and no h mismatch occurred inside the frame.
  - Then ck, the line counter and active are cleared.
- Coincident hs_start and vs_start:
  - The line closes first, then the frame closes.
  - The new frame's line counter starts at 1, i.e. the coincident line belongs to the new frame.
- State machine:
  - IDLE: on vs_start go to MEASURE. No frame_done; counters are cleared.
  - MEASURE: on frame close, go to LOCKED if the frame matches, else stay in MEASURE.
  - LOCKED: on frame close, stay if the frame matches, else go to MEASURE.
  - locked = 1 in LOCKED, registered, updated on the same clk as frame_done.
- Errors:
  - err_* flags are sticky until clr_err = 1.
  - If a set condition coincides with clr_err, set wins.
- Checksum arithmetic is modulo 2^CK_W. The rgb word is 24 bits, zero-extended to CK_W.
- rst asserted mid-frame aborts immediately. After release, behaviour is identical to power-up: IDLE, and no frame_done until a full frame is observed.
- Latency:
  - Input to px_en decision: 2 clk.
  - vs_start sample to frame_done: 1 clk.

Decomposition:
- Package vga_rx_pkg holds:
  - the state enum (IDLE, MEASURE, LOCKED);
  - the nominal 640x480@60 constants;
  - a checksum-step function (rotl-xor).
- One sub-module, vga_rx_sampler: two-stage registering of inputs, px_en generation, hs_start/vs_start edge detection.
- Counters, checks and the FSM stay in vga_rx_monitor.

Test Plan:
- Small mode H_ACTIVE=4, H_TOTAL=8, V_ACTIVE=3, V_TOTAL=5, vgaclk = clk/2, 3 clean frames, pixel value (line*16+col) -> first frame_done with locked=0→1, v_meas=5, h_meas=8, frame_cksum equal to the bench model, no err flags.
- Same mode, line 2 of frame 2 given 9 pixel clocks -> err_h=1, locked drops to 0 at frame 2 close; next clean frame -> locked=1 again, err_h stays 1 until clr_err.
- 6 lines in one frame -> err_v=1, v_meas=6, locked=0; clr_err in the same clk as a new err_v set -> err_v remains 1.
- blank_b held low for one extra pixel in frame 3 -> err_act=1, frame_cksum differs from the golden value.
- hs_start and vs_start on the same pixel every frame -> line counter of the new frame starts at 1, v_meas=5, locked=1.
- rst pulsed mid-frame 2 -> all outputs 0 within the same clk; no frame_done until one full frame after the next vs_start; frame_count restarts at 1.
